// File: rtl/axis_wide_to_narrow_tx.sv
// Splits each wide AXI4-Stream beat (NUM_WORDS x DATA_W) into NUM_WORDS narrow beats.
// A single hold register is used, so a new wide beat is accepted in the cycle its predecessor's last word leaves.
module axis_wide_to_narrow_tx #(
  parameter int DATA_W    = 64,
  parameter int NUM_WORDS = 17,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_axis_tready,
  input  logic [DATA_W*NUM_WORDS-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [31:0]                 pkt_count
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The reset is asserted asynchronously and released on an aclk edge, so no flop
  // sees its reset deassert close to a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_WORDS-1:0][DATA_W-1:0]   hold_q;
  logic                               hold_last_q;
  logic [31:0]                        pkt_count_q;
  logic                               load;
  logic                               last_word;
  logic [IDX_W-1:0]                   word_sel;

  assign last_word = (idx_q == LAST_IDX);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load          = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_axis_tready = rst_n;
        if (s_axis_tvalid && rst_n) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        // Upstream may only hand over a new beat as the final held word leaves.
        s_axis_tready = m_axis_tready && last_word;
        if (m_axis_tready) begin
          if (!last_word) begin
            idx_d = idx_q + 1'b1;
          end else if (s_axis_tvalid) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the wide hold register is reset (not just the control) because the
  // narrow data output must read as zero while in reset; a mid-packet reset drops the beat.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_last_q <= 1'b0;
    end else if (load) begin
      hold_q      <= s_axis_tdata;
      hold_last_q <= s_axis_tlast;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign word_sel      = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
  assign m_axis_tdata  = hold_q[word_sel];
  assign m_axis_tlast  = (state_q == SEND) && hold_last_q && last_word;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_wide_to_narrow_tx.sv
// Self-checking bench: three converter instances (2-word LSB-first, 2-word MSB-first, 17-word)
// driven from one directed sequence and compared against a queue-based word-order model.
module tb_axis_wide_to_narrow_tx;

  localparam int DW   = 64;
  localparam int MAXW = DW * 17;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  int cur     = 0;
  int cur_nw  = 2;
  bit cur_lsb = 1'b1;

  logic            drv_tvalid = 1'b0;
  logic            drv_tlast  = 1'b0;
  logic            drv_mready = 1'b0;
  logic [MAXW-1:0] drv_tdata  = '0;

  logic act_a, act_b, act_c;
  assign act_a = (cur == 0);
  assign act_b = (cur == 1);
  assign act_c = (cur == 2);

  logic        s_tready_a, m_tvalid_a, m_tlast_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b;
  logic        s_tready_c, m_tvalid_c, m_tlast_c;
  logic [63:0] m_tdata_a, m_tdata_b, m_tdata_c;
  logic [31:0] pkt_a, pkt_b, pkt_c;

  axis_wide_to_narrow_tx #(.DATA_W(64), .NUM_WORDS(2), .LSB_FIRST(1'b1)) u_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_tready_a), .s_axis_tdata(act_a ? drv_tdata[127:0] : 128'h0),
    .s_axis_tvalid(drv_tvalid & act_a), .s_axis_tlast(drv_tlast & act_a),
    .m_axis_tready(drv_mready & act_a), .m_axis_tdata(m_tdata_a),
    .m_axis_tvalid(m_tvalid_a), .m_axis_tlast(m_tlast_a), .pkt_count(pkt_a)
  );

  axis_wide_to_narrow_tx #(.DATA_W(64), .NUM_WORDS(2), .LSB_FIRST(1'b0)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_tready_b), .s_axis_tdata(act_b ? drv_tdata[127:0] : 128'h0),
    .s_axis_tvalid(drv_tvalid & act_b), .s_axis_tlast(drv_tlast & act_b),
    .m_axis_tready(drv_mready & act_b), .m_axis_tdata(m_tdata_b),
    .m_axis_tvalid(m_tvalid_b), .m_axis_tlast(m_tlast_b), .pkt_count(pkt_b)
  );

  axis_wide_to_narrow_tx #(.DATA_W(64), .NUM_WORDS(17), .LSB_FIRST(1'b1)) u_c (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_tready_c), .s_axis_tdata(act_c ? drv_tdata : {MAXW{1'b0}}),
    .s_axis_tvalid(drv_tvalid & act_c), .s_axis_tlast(drv_tlast & act_c),
    .m_axis_tready(drv_mready & act_c), .m_axis_tdata(m_tdata_c),
    .m_axis_tvalid(m_tvalid_c), .m_axis_tlast(m_tlast_c), .pkt_count(pkt_c)
  );

  logic        o_sready, o_tvalid, o_tlast;
  logic [63:0] o_tdata;
  logic [31:0] o_pkt;

  always_comb begin
    o_sready = s_tready_a;
    o_tvalid = m_tvalid_a;
    o_tlast  = m_tlast_a;
    o_tdata  = m_tdata_a;
    o_pkt    = pkt_a;
    if (cur == 1) begin
      o_sready = s_tready_b; o_tvalid = m_tvalid_b; o_tlast = m_tlast_b;
      o_tdata  = m_tdata_b;  o_pkt    = pkt_b;
    end else if (cur == 2) begin
      o_sready = s_tready_c; o_tvalid = m_tvalid_c; o_tlast = m_tlast_c;
      o_tdata  = m_tdata_c;  o_pkt    = pkt_c;
    end
  end

  // Reference model: pending wide beats, and the narrow words they must become.
  logic [MAXW-1:0] src_d[$];
  bit              src_l[$];
  logic [63:0]     exp_d[$];
  bit              exp_l[$];
  int              exp_p[$];
  logic [63:0]     obs_log[$];
  int              exp_pkts[3];

  task automatic check(input string tag, input logic [MAXW-1:0] obs, input logic [MAXW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAXW-1:0] rand_wide();
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic add_beat(input logic [MAXW-1:0] d, input bit last);
    int pos;
    src_d.push_back(d);
    src_l.push_back(last);
    for (int k = 0; k < cur_nw; k++) begin
      pos = cur_lsb ? k : (cur_nw - 1 - k);
      exp_d.push_back(d[pos*DW +: DW]);
      exp_l.push_back(last && (k == cur_nw - 1));
      exp_p.push_back(k);
    end
  endtask

  task automatic clear_model();
    src_d.delete(); src_l.delete();
    exp_d.delete(); exp_l.delete(); exp_p.delete();
    obs_log.delete();
  endtask

  // mode 0: sink always ready; 1: ready pattern 1,0,0; 2: random ready.
  task automatic stream(input int mode, input int stop_after, input int budget,
                        output int first_cyc, output int last_cyc);
    int          cyc = 0;
    int          nhs = 0;
    bit          stall_prev = 1'b0;
    bit          idle_hs = 1'b0;
    logic [63:0] pd = '0;
    logic        pl = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    while (exp_d.size() > 0 && (stop_after == 0 || nhs < stop_after)) begin
      if (cyc >= budget) begin
        checks++;
        failures++;
        $error("FAIL timeout observed=%0d_words_pending expected=0", exp_d.size());
        clear_model();
        break;
      end
      @(negedge aclk);
      case (mode)
        0:       drv_mready = 1'b1;
        1:       drv_mready = (cyc % 3 == 0);
        default: drv_mready = 1'($urandom_range(0, 1));
      endcase
      drv_tvalid = (src_d.size() > 0);
      drv_tdata  = (src_d.size() > 0) ? src_d[0] : '0;
      drv_tlast  = (src_l.size() > 0) ? src_l[0] : 1'b0;
      #1;
      if (idle_hs) check("first_word_latency", o_tvalid, 1'b1);
      if (stall_prev) begin
        check("stall_tvalid", o_tvalid, 1'b1);
        check("stall_tdata", o_tdata, pd);
        check("stall_tlast", o_tlast, pl);
      end
      if (o_tvalid) begin
        if (exp_d.size() == 0) begin
          check("spurious_tvalid", o_tvalid, 1'b0);
        end else begin
          check("s_tready_in_send", o_sready, drv_mready && (exp_p[0] == cur_nw - 1));
          if (drv_mready) begin
            check("m_tdata", o_tdata, exp_d[0]);
            check("m_tlast", o_tlast, exp_l[0]);
            if (exp_l[0]) exp_pkts[cur]++;
            obs_log.push_back(o_tdata);
            void'(exp_d.pop_front()); void'(exp_l.pop_front()); void'(exp_p.pop_front());
            if (nhs == 0) first_cyc = cyc;
            last_cyc = cyc;
            nhs++;
          end
        end
      end
      idle_hs = drv_tvalid && o_sready && !o_tvalid;
      if (drv_tvalid && o_sready) begin
        void'(src_d.pop_front());
        void'(src_l.pop_front());
      end
      stall_prev = o_tvalid && !drv_mready;
      pd = o_tdata;
      pl = o_tlast;
      cyc++;
    end
    @(negedge aclk);
    drv_tvalid = 1'b0;
    drv_tlast  = 1'b0;
    drv_mready = 1'b0;
    drv_tdata  = '0;
  endtask

  initial begin
    int f, l;
    logic [MAXW-1:0] beat;
    logic [MAXW-1:0] spec_beat;
    spec_beat = '0;
    spec_beat[127:0] = 128'h02000100020002000100020001000100;
    exp_pkts = '{0, 0, 0};

    // Reset state
    #12;
    check("rst_tvalid", o_tvalid, 1'b0);
    check("rst_tlast", o_tlast, 1'b0);
    check("rst_tdata", o_tdata, 64'h0);
    check("rst_sready", o_sready, 1'b0);
    check("rst_pkt", o_pkt, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    #1;
    check("idle_sready", o_sready, 1'b1);
    check("idle_tvalid", o_tvalid, 1'b0);

    // 1: single beat, LSB word first
    cur = 0; cur_nw = 2; cur_lsb = 1'b1;
    clear_model();
    add_beat(spec_beat, 1'b1);
    stream(0, 0, 100, f, l);
    check("t1_word0", obs_log[0], 64'h0100020001000100);
    check("t1_word1", obs_log[1], 64'h0200010002000200);
    check("t1_spacing", l - f, 1);
    check("t1_pkt", o_pkt, exp_pkts[0]);

    // 2: MSB word first
    cur = 1; cur_nw = 2; cur_lsb = 1'b0;
    clear_model();
    add_beat(spec_beat, 1'b1);
    stream(0, 0, 100, f, l);
    check("t2_word0", obs_log[0], 64'h0200010002000200);
    check("t2_word1", obs_log[1], 64'h0100020001000100);
    check("t2_pkt", o_pkt, exp_pkts[1]);

    // 3: back-to-back beats, zero bubble
    cur = 0; cur_nw = 2; cur_lsb = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) add_beat(rand_wide(), i == 3);
    stream(0, 0, 100, f, l);
    check("t3_words", obs_log.size(), 8);
    check("t3_consecutive", l - f, 7);
    check("t3_pkt", o_pkt, exp_pkts[0]);

    // 4: back-pressure, fixed pattern then random
    clear_model();
    add_beat(rand_wide(), 1'b0); add_beat(rand_wide(), 1'b1);
    add_beat(rand_wide(), 1'b1);
    add_beat(rand_wide(), 1'b0); add_beat(rand_wide(), 1'b1);
    stream(1, 0, 500, f, l);
    check("t4_words", obs_log.size(), 10);
    check("t4_pkt", o_pkt, exp_pkts[0]);
    clear_model();
    for (int i = 0; i < 6; i++) add_beat(rand_wide(), i == 2 || i == 5);
    stream(2, 0, 500, f, l);
    check("t4r_words", obs_log.size(), 12);
    check("t4r_pkt", o_pkt, exp_pkts[0]);

    // 5: reset after first narrow word of a packet
    clear_model();
    beat = rand_wide();
    add_beat(beat, 1'b1);
    stream(0, 1, 100, f, l);
    #1;
    check("t5_pre_tvalid", o_tvalid, 1'b1);
    check("t5_pre_word1", o_tdata, beat[127:64]);
    #1;
    aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", o_tvalid, 1'b0);
    check("t5_rst_tlast", o_tlast, 1'b0);
    check("t5_rst_tdata", o_tdata, 64'h0);
    check("t5_rst_sready", o_sready, 1'b0);
    check("t5_rst_pkt", o_pkt, 32'h0);
    clear_model();
    exp_pkts = '{0, 0, 0};
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    beat = rand_wide();
    add_beat(beat, 1'b1);
    stream(0, 0, 100, f, l);
    check("t5_new_word0", obs_log[0], beat[63:0]);
    check("t5_new_pkt", o_pkt, exp_pkts[0]);

    // 6: 17-word instance, 3-beat packet under random back-pressure
    cur = 2; cur_nw = 17; cur_lsb = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) add_beat(rand_wide(), i == 2);
    stream(2, 0, 2000, f, l);
    check("t6_words", obs_log.size(), 51);
    check("t6_pkt", o_pkt, exp_pkts[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
